// File: rtl/fifomult_par_if.sv
// Operand-in / product-out handshake bundle for fifomult_par.
// The master side is the producer and consumer; the slave side is the multiplier.
interface fifomult_par_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  logic [DATA_W-1:0]          data_in;
  logic                       data_in_parity;
  logic                       data_in_valid;
  logic                       busy_out;
  logic [2*DATA_W-1:0]        data_out;
  logic                       data_out_parity;
  logic                       data_out_valid;
  logic                       data_out_ready;
  logic                       data_in_parity_error;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  modport master (
    output data_in, data_in_parity, data_in_valid, data_out_ready,
    input  busy_out, data_out, data_out_parity, data_out_valid,
           data_in_parity_error, fifo_count
  );

  modport slave (
    input  data_in, data_in_parity, data_in_valid, data_out_ready,
    output busy_out, data_out, data_out_parity, data_out_valid,
           data_in_parity_error, fifo_count
  );
endinterface

// File: rtl/fifomult_par.sv
// Parity-checked A/B operand collector feeding a pair FIFO and a two-stage
// multiplier pipeline (S1 pair register, then registered product).
module fifomult_par #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 1
) (
  input logic           clk,
  input logic           rst_n,
  fifomult_par_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * DATA_W + 1;

  typedef enum logic {PH_A, PH_B} phase_t;

  phase_t              phase;
  logic [DATA_W-1:0]   a_hold;
  logic                a_err;
  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                s1_valid;
  logic [DATA_W-1:0]   s1_a;
  logic [DATA_W-1:0]   s1_b;
  logic                s1_err;
  logic                out_valid;
  logic                out_parity;
  logic                out_err;
  logic [2*DATA_W-1:0] out_data;

  logic                busy;
  logic                accept;
  logic                word_err;
  logic                push;
  logic                pop;
  logic                out_adv;
  logic                sgn_a;
  logic                sgn_b;
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] result;

  assign busy     = (count == CW'(DEPTH));
  assign accept   = bus.data_in_valid && !busy;
  assign word_err = (^bus.data_in) != bus.data_in_parity;
  assign push     = accept && (phase == PH_B);
  assign out_adv  = !out_valid || bus.data_out_ready;
  assign pop      = (count != '0) && (!s1_valid || out_adv);

  // Sign-extending to full product width makes one truncating multiply
  // correct for both two's-complement and unsigned operands.
  assign sgn_a   = (SIGNED != 0) && s1_a[DATA_W-1];
  assign sgn_b   = (SIGNED != 0) && s1_b[DATA_W-1];
  assign ext_a   = {{DATA_W{sgn_a}}, s1_a};
  assign ext_b   = {{DATA_W{sgn_b}}, s1_b};
  assign product = ext_a * ext_b;
  assign result  = s1_err ? '0 : product;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= {a_hold, bus.data_in, a_err | word_err};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= PH_A;
      a_hold     <= '0;
      a_err      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_err     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (accept) begin
        if (phase == PH_A) begin
          a_hold <= bus.data_in;
          a_err  <= word_err;
          phase  <= PH_B;
        end else begin
          phase  <= PH_A;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop) begin
        s1_valid                 <= 1'b1;
        {s1_a, s1_b, s1_err}     <= mem[rd_ptr];
      end else if (out_adv) begin
        s1_valid                 <= 1'b0;
      end

      // Output fields are zeroed when no result moves in so the error flag
      // can only ever be seen alongside a valid result.
      if (out_adv) begin
        out_valid  <= s1_valid;
        out_data   <= s1_valid ? result : '0;
        out_parity <= s1_valid && (^result);
        out_err    <= s1_valid && s1_err;
      end
    end
  end

  assign bus.busy_out             = busy;
  assign bus.fifo_count           = count;
  assign bus.data_out             = out_data;
  assign bus.data_out_parity      = out_parity;
  assign bus.data_out_valid       = out_valid;
  assign bus.data_in_parity_error = out_err;
endmodule

// File: doc/fifomult_par.md
FIFOMULT_PAR -- requirements
Module: fifomult_par

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the operand width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of operand-pair FIFO entries (power of two, 2..64).
REQ-003 The block SHALL have parameter SIGNED, default 1: 1 selects a two's-complement product, 0 selects an unsigned product.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 data_in  input  DATA_W  operand word; the first word accepted is A, the next is B.
REQ-007 data_in_parity  input  1  even-parity bit for data_in; the bit is correct when it equals the XOR of all data_in bits.
REQ-008 data_in_valid  input  1  data_in and data_in_parity are offered this cycle.
REQ-009 busy_out  output  1  input not accepted this cycle.
REQ-010 data_out  output  2*DATA_W  product result.
REQ-011 data_out_parity  output  1  XOR of all data_out bits.
REQ-012 data_out_valid  output  1  result presented.
REQ-013 data_out_ready  input  1  consumer accepts the result.
REQ-014 data_in_parity_error  output  1  A or B of the presented result had wrong parity.
REQ-015 fifo_count  output  $clog2(DEPTH+1)  number of pairs held in the FIFO.

Function
REQ-016 A word SHALL be accepted on a rising edge where data_in_valid=1, busy_out=0 and rst_n=1; no other word is accepted.
REQ-017 An internal phase bit SHALL alternate A/B on each accepted word; A and its parity error flag SHALL be held until B is accepted.
REQ-018 Gaps of any length SHALL be allowed between A and B.
REQ-019 On B acceptance, {A, B, err} SHALL be pushed to the FIFO, where err = (A parity wrong) OR (B parity wrong).
REQ-020 busy_out SHALL equal (fifo_count==DEPTH), derived from registered state; a push while full cannot occur.
REQ-021 The datapath SHALL have two stages: S1 holds the popped pair, and the output register holds the result.
REQ-022 A pop into S1 SHALL occur when the FIFO is non-empty and S1 is empty or advancing.
REQ-023 S1 SHALL advance into the output register when the output register is empty or (data_out_valid AND data_out_ready).
REQ-024 When the FIFO is empty and the pipeline is idle, data_out_valid SHALL rise after the 2nd rising edge following B acceptance.
REQ-025 Throughput SHALL be one result per cycle while data_out_ready=1.
REQ-026 While data_out_valid=1 and data_out_ready=0, data_out, data_out_parity and data_in_parity_error SHALL be held stable, and S1 and the FIFO pop SHALL stall.
REQ-027 A simultaneous push and pop SHALL leave fifo_count unchanged; a pop from empty SHALL never occur.
REQ-028 Results SHALL be delivered in strict arrival order with no loss; total capacity is DEPTH+2 pairs.
REQ-029 When err=0, data_out SHALL equal A*B at full 2*DATA_W width, signed or unsigned per SIGNED, with no truncation.
REQ-030 When err=1, data_out SHALL be 0, data_out_parity SHALL be 0, and data_in_parity_error SHALL be 1.
REQ-031 data_in_parity_error SHALL be valid only while data_out_valid=1 and SHALL be 0 otherwise.

Reset
REQ-032 While rst_n=0 at a rising edge, the FIFO, phase bit (to A), held A, S1 and the output register SHALL clear.
REQ-033 After reset, data_out=0, data_out_parity=0, data_out_valid=0, data_in_parity_error=0, busy_out=0 and fifo_count=0.
REQ-034 Inputs SHALL be ignored during reset; a reset mid-operation SHALL discard the pending A and all queued and in-flight results without emitting them.
REQ-035 The first word accepted after reset SHALL be treated as A.

Verification (DATA_W=16, DEPTH=4, ready=1 unless stated)
REQ-036 SIGNED=1, A=16'h7FFF, B=16'h7FFF, correct parity -> data_out=32'h3FFF0001, parity=1, error=0, valid 2 edges after B.
REQ-037 SIGNED=1, A=16'h8000, B=16'hFFFF -> data_out=32'h00008000, parity=1, error=0.
REQ-038 A=16'h0001 with parity=0, B=16'h0003 correct -> data_out=0, parity=0, error=1, one valid pulse.
REQ-039 ready=0, send pairs continuously -> exactly 6 pairs accepted, then busy_out=1 and fifo_count=4; ready=1 -> 6 results in order, busy_out falls after the first handshake.
REQ-040 Accept A=16'h0005, pulse rst_n=0 one cycle, then send 16'h0002, 16'h0003 -> single result 32'h00000006, no stale output.
REQ-041 SIGNED=0, A=B=16'hFFFF -> data_out=32'hFFFE0001, parity=0.
